// File: rtl/trivium_seq_ctrl_if.sv
// Handshake and control bundle between the Trivium sequencing controller and its environment.
// master = environment/driver side, slave = controller side.
interface trivium_seq_ctrl_if #(
   parameter int LEN_W = 16
) ();
   logic             start_i;
   logic             abort_i;
   logic [LEN_W-1:0] len_i;
   logic             din_i;
   logic             din_vld_i;
   logic             din_rdy_o;
   logic             sr_ce_o;
   logic             sr_in_o;
   logic             cipher_ld_o;
   logic             cipher_ce_o;
   logic             ks_vld_o;
   logic             ks_rdy_i;
   logic             busy_o;
   logic             done_o;

   modport master (
      output start_i, abort_i, len_i, din_i, din_vld_i, ks_rdy_i,
      input  din_rdy_o, sr_ce_o, sr_in_o, cipher_ld_o, cipher_ce_o, ks_vld_o, busy_o, done_o
   );

   modport slave (
      input  start_i, abort_i, len_i, din_i, din_vld_i, ks_rdy_i,
      output din_rdy_o, sr_ce_o, sr_in_o, cipher_ld_o, cipher_ce_o, ks_vld_o, busy_o, done_o
   );
endinterface

// File: rtl/trivium_seq_ctrl.sv
// Trivium sequencing controller: serial key/IV load, core load pulse, warm-up rounds, then
// length-limited keystream delivery under consumer backpressure. Data path is zero-latency combinational.
module trivium_seq_ctrl #(
   parameter int KEY_SZ = 80,
   parameter int IV_SZ  = 80,
   parameter int WARMUP = 1152,
   parameter int LEN_W  = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   trivium_seq_ctrl_if.slave  bus
);
   localparam int LOAD_BITS = IV_SZ + KEY_SZ;
   localparam int LEN_MAX   = (1 << LEN_W) - 1;
   localparam int MAX_A     = (LOAD_BITS > WARMUP) ? LOAD_BITS : WARMUP;
   localparam int CNT_MAX   = (MAX_A > LEN_MAX) ? MAX_A : LEN_MAX;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_XFER, ST_WARMUP, ST_RUN, ST_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;

   logic din_rdy, sr_ce, sr_in, cipher_ld, cipher_ce, ks_vld, busy, done;
   logic accept;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      din_rdy   = 1'b0;
      sr_ce     = 1'b0;
      sr_in     = 1'b0;
      cipher_ld = 1'b0;
      cipher_ce = 1'b0;
      ks_vld    = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      busy      = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               state_d = ST_LOAD;
               len_d   = bus.len_i;
               cnt_d   = '0;
            end
         end
         ST_LOAD: begin
            din_rdy = 1'b1;
            accept  = bus.din_vld_i;
            sr_ce   = accept;
            sr_in   = accept & bus.din_i;
            if (accept) begin
               if (cnt_q == CNT_W'(LOAD_BITS - 1)) begin
                  state_d = ST_XFER;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_XFER: begin
            cipher_ld = 1'b1;
            state_d   = ST_WARMUP;
            cnt_d     = '0;
         end
         ST_WARMUP: begin
            cipher_ce = 1'b1;
            if (cnt_q == CNT_W'(WARMUP - 1)) begin
               cnt_d   = '0;
               state_d = (len_q == '0) ? ST_DONE : ST_RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            ks_vld    = 1'b1;
            cipher_ce = bus.ks_rdy_i;
            if (bus.ks_rdy_i) begin
               // RUN is only entered with a non-zero length, so len_q-1 cannot underflow.
               if (cnt_q == CNT_W'(len_q - 1'b1)) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (bus.abort_i) begin
         state_d   = ST_IDLE;
         cnt_d     = '0;
         sr_ce     = 1'b0;
         cipher_ld = 1'b0;
         cipher_ce = 1'b0;
      end

      // Outputs stay quiet while reset is held, whatever the current state.
      if (rst_i) begin
         din_rdy   = 1'b0;
         sr_ce     = 1'b0;
         sr_in     = 1'b0;
         cipher_ld = 1'b0;
         cipher_ce = 1'b0;
         ks_vld    = 1'b0;
         busy      = 1'b0;
         done      = 1'b0;
      end
   end

   assign bus.din_rdy_o   = din_rdy;
   assign bus.sr_ce_o     = sr_ce;
   assign bus.sr_in_o     = sr_in;
   assign bus.cipher_ld_o = cipher_ld;
   assign bus.cipher_ce_o = cipher_ce;
   assign bus.ks_vld_o    = ks_vld;
   assign bus.busy_o      = busy;
   assign bus.done_o      = done;
endmodule

// File: tb/tb_trivium_seq_ctrl.sv
// Self-checking bench for trivium_seq_ctrl: key/IV bit scoreboard plus phase-by-phase cycle checks.
module tb_trivium_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   bit   exp_q[$];

   always #5 clk = ~clk;

   trivium_seq_ctrl_if #(.LEN_W(16)) bus ();

   trivium_seq_ctrl #(
      .KEY_SZ(80), .IV_SZ(80), .WARMUP(1152), .LEN_W(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      bus.start_i   = 1'b0;
      bus.abort_i   = 1'b0;
      bus.len_i     = '0;
      bus.din_i     = 1'b0;
      bus.din_vld_i = 1'b0;
      bus.ks_rdy_i  = 1'b0;
   endtask

   function automatic logic [7:0] outs();
      return {bus.busy_o, bus.done_o, bus.din_rdy_o, bus.sr_ce_o,
              bus.sr_in_o, bus.cipher_ld_o, bus.cipher_ce_o, bus.ks_vld_o};
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      bus.start_i   = 1'b1;
      bus.din_vld_i = 1'b1;
      bus.ks_rdy_i  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cyc();
         settle();
         chk_cnt++;
         if (outs() !== 8'h00) $display("FAIL reset_outs: got %b want 00000000", outs());
         else pass_cnt++;
      end
      idle_inputs();
      rst = 1'b0;
      next_cyc();
      settle();
      chk_cnt++;
      if (outs() !== 8'h00) $display("FAIL post_reset_outs: got %b want 00000000", outs());
      else pass_cnt++;
      next_cyc();
   endtask

   // One complete session: start, 160-bit load, XFER, warm-up, RUN, DONE.
   task automatic run_txn(input int len, input bit throttle, input int gap,
                          input bit poke_start, input string tag);
      int shifts, ncyc, ce, takes;
      bit eb;
      exp_q.delete();
      bus.len_i   = 16'(len);
      bus.start_i = 1'b1;
      settle();
      chk_cnt++;
      if (bus.busy_o !== 1'b0) $display("FAIL %s idle_busy: got %b want 0", tag, bus.busy_o);
      else pass_cnt++;
      next_cyc();
      bus.start_i = 1'b0;
      bus.len_i   = 16'hffff;

      shifts = 0;
      ncyc   = 0;
      while (shifts < 160 && ncyc < 1000) begin
         bus.din_vld_i = throttle ? (ncyc % 2 == 0) : 1'b1;
         bus.din_i     = 1'($urandom_range(0, 1));
         if (bus.din_vld_i) exp_q.push_back(bus.din_i);
         settle();
         chk_cnt++;
         if (bus.din_rdy_o !== 1'b1 || bus.sr_ce_o !== bus.din_vld_i)
            $display("FAIL %s load_hs: rdy=%b sr_ce=%b vld=%b at shift %0d", tag,
                     bus.din_rdy_o, bus.sr_ce_o, bus.din_vld_i, shifts);
         else pass_cnt++;
         if (bus.sr_ce_o === 1'b1 && exp_q.size() > 0) begin
            eb = exp_q.pop_front();
            shifts++;
            chk_cnt++;
            if (bus.sr_in_o !== eb) $display("FAIL %s sr_in: got %b want %b", tag, bus.sr_in_o, eb);
            else pass_cnt++;
         end
         next_cyc();
         ncyc++;
      end
      chk_cnt++;
      if (shifts != 160 || exp_q.size() != 0)
         $display("FAIL %s shift_count: got %0d want 160 (pending %0d)", tag, shifts, exp_q.size());
      else pass_cnt++;

      bus.din_vld_i = 1'b1;
      settle();
      chk_cnt++;
      if ({bus.din_rdy_o, bus.sr_ce_o, bus.cipher_ld_o, bus.cipher_ce_o} !== 4'b0010)
         $display("FAIL %s xfer: got rdy/ce/ld/cce=%b want 0010", tag,
                  {bus.din_rdy_o, bus.sr_ce_o, bus.cipher_ld_o, bus.cipher_ce_o});
      else pass_cnt++;
      next_cyc();
      bus.din_vld_i = 1'b0;

      ce = 0;
      while (ce < 2000) begin
         settle();
         if (bus.cipher_ce_o !== 1'b1) break;
         chk_cnt++;
         if (bus.ks_vld_o !== 1'b0 || bus.cipher_ld_o !== 1'b0)
            $display("FAIL %s warmup_outs: ks_vld=%b ld=%b want 0", tag, bus.ks_vld_o, bus.cipher_ld_o);
         else pass_cnt++;
         ce++;
         next_cyc();
      end
      chk_cnt++;
      if (ce != 1152) $display("FAIL %s warmup_len: got %0d want 1152", tag, ce);
      else pass_cnt++;

      takes = 0;
      ncyc  = 0;
      while (ncyc < 1000) begin
         bus.start_i  = poke_start;
         bus.ks_rdy_i = (gap == 0) ? 1'b1 : (ncyc % (gap + 1) == gap);
         settle();
         if (bus.ks_vld_o !== 1'b1) break;
         chk_cnt++;
         if (bus.cipher_ce_o !== bus.ks_rdy_i)
            $display("FAIL %s run_ce: got %b want %b", tag, bus.cipher_ce_o, bus.ks_rdy_i);
         else pass_cnt++;
         if (bus.ks_rdy_i) takes++;
         next_cyc();
         ncyc++;
      end
      chk_cnt++;
      if (takes != len) $display("FAIL %s take_count: got %0d want %0d", tag, takes, len);
      else pass_cnt++;

      chk_cnt++;
      if ({bus.done_o, bus.busy_o, bus.cipher_ce_o, bus.ks_vld_o} !== 4'b1100)
         $display("FAIL %s done_cycle: got done/busy/ce/vld=%b want 1100", tag,
                  {bus.done_o, bus.busy_o, bus.cipher_ce_o, bus.ks_vld_o});
      else pass_cnt++;
      next_cyc();
      bus.start_i  = 1'b0;
      bus.ks_rdy_i = 1'b0;
      settle();
      chk_cnt++;
      if (outs() !== 8'h00) $display("FAIL %s after_done: got %b want 00000000", tag, outs());
      else pass_cnt++;
      next_cyc();
      settle();
      chk_cnt++;
      if (bus.busy_o !== 1'b0) $display("FAIL %s stay_idle: busy got %b want 0", tag, bus.busy_o);
      else pass_cnt++;
      next_cyc();
   endtask

   task automatic test_nominal();
      run_txn(8, 1'b0, 0, 1'b0, "nominal");
   endtask

   task automatic test_throttled();
      run_txn(3, 1'b1, 0, 1'b0, "throttled");
   endtask

   task automatic test_zero_len();
      run_txn(0, 1'b0, 0, 1'b0, "zero_len");
   endtask

   task automatic test_backpressure();
      run_txn(4, 1'b0, 3, 1'b0, "backpressure");
   endtask

   task automatic test_abort();
      int ce;
      idle_inputs();
      bus.len_i   = 16'd5;
      bus.start_i = 1'b1;
      next_cyc();
      bus.start_i   = 1'b0;
      bus.din_vld_i = 1'b1;
      repeat (160) next_cyc();
      bus.din_vld_i = 1'b0;
      next_cyc();
      ce = 0;
      for (int i = 0; i < 500; i++) begin
         settle();
         if (bus.cipher_ce_o === 1'b1) ce++;
         next_cyc();
      end
      chk_cnt++;
      if (ce != 500) $display("FAIL abort_pre_ce: got %0d want 500", ce);
      else pass_cnt++;
      bus.abort_i = 1'b1;
      bus.start_i = 1'b1;
      settle();
      chk_cnt++;
      if ({bus.cipher_ce_o, bus.busy_o, bus.done_o} !== 3'b010)
         $display("FAIL abort_cycle: got ce/busy/done=%b want 010",
                  {bus.cipher_ce_o, bus.busy_o, bus.done_o});
      else pass_cnt++;
      next_cyc();
      bus.abort_i = 1'b0;
      bus.start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk_cnt++;
         if (outs() !== 8'h00) $display("FAIL abort_idle: got %b want 00000000", outs());
         else pass_cnt++;
         next_cyc();
      end
      run_txn(2, 1'b0, 0, 1'b0, "after_abort");
   endtask

   task automatic test_reset_mid_load();
      int shifts;
      idle_inputs();
      bus.len_i   = 16'd3;
      bus.start_i = 1'b1;
      next_cyc();
      bus.start_i   = 1'b0;
      bus.din_vld_i = 1'b1;
      shifts = 0;
      for (int i = 0; i < 37; i++) begin
         settle();
         if (bus.sr_ce_o === 1'b1) shifts++;
         next_cyc();
      end
      chk_cnt++;
      if (shifts != 37) $display("FAIL mid_load_shifts: got %0d want 37", shifts);
      else pass_cnt++;
      rst = 1'b1;
      settle();
      chk_cnt++;
      if (outs() !== 8'h00) $display("FAIL reset_in_load: got %b want 00000000", outs());
      else pass_cnt++;
      next_cyc();
      rst = 1'b0;
      bus.din_vld_i = 1'b0;
      settle();
      chk_cnt++;
      if (outs() !== 8'h00) $display("FAIL after_reset_load: got %b want 00000000", outs());
      else pass_cnt++;
      next_cyc();
      run_txn(3, 1'b0, 1, 1'b1, "post_reset");
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_nominal();
      test_throttled();
      test_zero_len();
      test_backpressure();
      test_abort();
      test_reset_mid_load();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
